// File: rtl/pipe_seq_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline sequencer and the stage modules.
//   state_t      : sequencer FSM states
//   NUM_STAGES   : pipeline depth (IF..WB)
//   MEM_DEPTH    : instruction-image lines, i.e. max fetches per run
//   CNT_W        : fetch/retire counter width, must hold MEM_DEPTH
//   IF_S..WB_S   : stage indices into the per-stage valid/enable vectors
package pipe_pkg;

  localparam int unsigned NUM_STAGES = 5;
  localparam int unsigned MEM_DEPTH  = 1024;
  localparam int unsigned CNT_W      = 11;

  localparam int unsigned IF_S  = 0;
  localparam int unsigned ID_S  = 1;
  localparam int unsigned EX_S  = 2;
  localparam int unsigned MEM_S = 3;
  localparam int unsigned WB_S  = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/pipe_seq_ctrl_if.sv
// Bundle between top-level run control / stage modules and the pipeline sequencer.
//   master : run control side, drives start/hazard/flush/halt_dec, observes status
//   slave  : sequencer side, drives stage_en/stage_vld/busy/opr_finished/counters
interface pipe_seq_ctrl_if #(
  parameter int unsigned CNT_W = pipe_pkg::CNT_W
);

  logic                            start;
  logic                            hazard;
  logic                            flush;
  logic                            halt_dec;
  logic [pipe_pkg::NUM_STAGES-1:0] stage_en;
  logic [pipe_pkg::NUM_STAGES-1:0] stage_vld;
  logic                            busy;
  logic                            opr_finished;
  logic [CNT_W-1:0]                fetch_cnt;
  logic [CNT_W-1:0]                retire_cnt;

  modport master (
    output start, hazard, flush, halt_dec,
    input  stage_en, stage_vld, busy, opr_finished, fetch_cnt, retire_cnt
  );

  modport slave (
    input  start, hazard, flush, halt_dec,
    output stage_en, stage_vld, busy, opr_finished, fetch_cnt, retire_cnt
  );

endinterface

// File: rtl/pipe_vld_shift.sv
// Per-stage valid shift register for the 5-stage pipeline.
//   clk, rstb : clock, asynchronous active-low reset
//   advance   : update valids this edge (low holds everything, used while idle)
//   fetch     : new instruction enters IF
//   stall     : freeze IF/ID, insert a bubble into EX
//   kill_if   : drop the instruction leaving IF (flush, or the slot behind a HALT)
//   kill_id   : drop the instruction leaving ID (flush)
//   vld       : registered per-stage valid
//   en        : per-stage work enable, IF/ID masked while stalled
module pipe_vld_shift
  import pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  advance,
  input  logic                  fetch,
  input  logic                  stall,
  input  logic                  kill_if,
  input  logic                  kill_id,
  output logic [NUM_STAGES-1:0] vld,
  output logic [NUM_STAGES-1:0] en
);

  logic [NUM_STAGES-1:0] vld_q, vld_d;

  always_comb begin
    vld_d = vld_q;
    if (advance) begin
      if (stall) begin
        vld_d[IF_S] = vld_q[IF_S];
        vld_d[ID_S] = vld_q[ID_S];
        vld_d[EX_S] = 1'b0;
      end else begin
        vld_d[IF_S] = fetch;
        vld_d[ID_S] = vld_q[IF_S] & ~kill_if;
        vld_d[EX_S] = vld_q[ID_S] & ~kill_id;
      end
      // Back half of the pipe never stalls.
      vld_d[MEM_S] = vld_q[EX_S];
      vld_d[WB_S]  = vld_q[MEM_S];
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  always_comb begin
    en = vld_q;
    if (stall) begin
      en[IF_S] = 1'b0;
      en[ID_S] = 1'b0;
    end
  end

  assign vld = vld_q;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Sequencer for the 5-stage datapath: start-up fill, RAW stalls, branch flushes,
// HALT and end-of-image drain, with a one-cycle opr_finished once the pipe is empty.
//   clk, rstb : clock, asynchronous active-low reset
//   bus       : slave side of pipe_seq_ctrl_if (control inputs, enables, status, counters)
module pipe_seq_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = pipe_pkg::MEM_DEPTH,
  parameter int unsigned CNT_W     = pipe_pkg::CNT_W
) (
  input  logic           clk,
  input  logic           rstb,
  pipe_seq_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] MaxCnt  = CNT_W'(MEM_DEPTH);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MEM_DEPTH - 1);

  state_t                state_q;
  logic [CNT_W-1:0]      fetch_cnt_q;
  logic [CNT_W-1:0]      retire_cnt_q;
  logic [NUM_STAGES-1:0] vld;
  logic [NUM_STAGES-1:0] en;
  logic                  in_run;
  logic                  stall;
  logic                  halt;
  logic                  fetch;

  assign in_run = (state_q == RUN);

  // Priority flush > hazard > halt; halt_dec only counts while still fetching.
  assign stall = bus.hazard & vld[ID_S] & ~bus.flush;
  assign halt  = in_run & bus.halt_dec & vld[ID_S] & ~bus.flush & ~stall;
  assign fetch = in_run & ~stall & ~halt & (fetch_cnt_q < MaxCnt);

  pipe_vld_shift u_vld_shift (
    .clk     (clk),
    .rstb    (rstb),
    .advance (state_q != IDLE),
    .fetch   (fetch),
    .stall   (stall),
    // On HALT the instruction sitting in IF is the one behind it and must not issue.
    .kill_if (bus.flush | halt),
    .kill_id (bus.flush),
    .vld     (vld),
    .en      (en)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= IDLE;
      fetch_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (fetch) begin
        fetch_cnt_q <= fetch_cnt_q + 1'b1;
      end
      if (vld[WB_S]) begin
        retire_cnt_q <= retire_cnt_q + 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q      <= RUN;
            fetch_cnt_q  <= '0;
            retire_cnt_q <= '0;
          end
        end
        RUN: begin
          if (halt || (fetch && fetch_cnt_q == LastCnt)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (vld == '0) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.stage_en     = en;
  assign bus.stage_vld    = vld;
  assign bus.busy         = (state_q != IDLE);
  assign bus.opr_finished = (state_q == DONE);
  assign bus.fetch_cnt    = fetch_cnt_q;
  assign bus.retire_cnt   = retire_cnt_q;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
module tb_pipe_seq_ctrl;

  localparam int unsigned MD = 8;
  localparam int unsigned CW = 11;

  localparam int PIdle  = 0;
  localparam int PRun   = 1;
  localparam int PDrain = 2;
  localparam int PDone  = 3;

  logic clk;
  logic rstb;

  pipe_seq_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_seq_ctrl #(
    .MEM_DEPTH (MD),
    .CNT_W     (CW)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  // Behavioural reference: valid bits per stage, run phase and counters.
  logic [4:0] m_vld;
  int         m_ph;
  int         m_fc;
  int         m_rc;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_ph  <= PIdle;
      m_vld <= '0;
      m_fc  <= 0;
      m_rc  <= 0;
    end else begin : upd
      logic       st, hl, fe;
      logic [4:0] nv;
      st = bus.hazard && m_vld[1] && !bus.flush;
      hl = (m_ph == PRun) && bus.halt_dec && m_vld[1] && !bus.flush && !st;
      fe = (m_ph == PRun) && !st && !hl && (m_fc < MD);
      if (m_ph == PIdle) begin
        if (bus.start) begin
          m_ph <= PRun;
          m_fc <= 0;
          m_rc <= 0;
        end
      end else begin
        if (st) nv = {m_vld[3:2], 1'b0, m_vld[1:0]};
        else    nv = {m_vld[3:2], m_vld[1] & ~bus.flush, m_vld[0] & ~bus.flush & ~hl, fe};
        m_vld <= nv;
        m_rc  <= m_rc + int'(m_vld[4]);
        m_fc  <= m_fc + int'(fe);
        case (m_ph)
          PRun:   if (hl || (fe && m_fc + 1 == MD)) m_ph <= PDrain;
          PDrain: if (m_vld == 5'b0) m_ph <= PDone;
          default: m_ph <= PIdle;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rstb) begin : cmp
      logic       st;
      logic [4:0] exp_en;
      st = bus.hazard && m_vld[1] && !bus.flush;
      exp_en = m_vld;
      if (st) exp_en[1:0] = 2'b00;
      check("stage_vld", int'(bus.stage_vld), int'(m_vld));
      check("stage_en", int'(bus.stage_en), int'(exp_en));
      check("busy", int'(bus.busy), int'(m_ph != PIdle));
      check("opr_finished", int'(bus.opr_finished), int'(m_ph == PDone));
      check("fetch_cnt", int'(bus.fetch_cnt), m_fc);
      check("retire_cnt", int'(bus.retire_cnt), m_rc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.start    = 1'b0;
    bus.hazard   = 1'b0;
    bus.flush    = 1'b0;
    bus.halt_dec = 1'b0;
  endtask

  task automatic start_run();
    int g;
    g = 0;
    while (bus.busy && g < 50) begin
      step();
      g++;
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_finish(output int cyc);
    cyc = 0;
    while (!bus.opr_finished && cyc < 400) begin
      step();
      cyc++;
    end
    if (!bus.opr_finished) check("finish_timeout", 0, 1);
  endtask

  initial begin
    int cyc;
    int fc_before;
    clear_in();
    rstb = 1'b0;
    #12;
    check("rst_vld", int'(bus.stage_vld), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_cnt", int'(bus.fetch_cnt) + int'(bus.retire_cnt), 0);
    @(negedge clk);
    rstb = 1'b1;
    step();

    // Plain run: fetch E1..E8, drain, finish after E14.
    start_run();
    wait_finish(cyc);
    check("t1_finish_cycle", cyc, 14);
    check("t1_fetch", int'(bus.fetch_cnt), 8);
    check("t1_retire", int'(bus.retire_cnt), 8);
    step();
    check("t1_pulse_one_cycle", int'(bus.opr_finished), 0);

    // Hazard held two cycles on a full pipe.
    start_run();
    repeat (5) step();
    check("t2_full", int'(bus.stage_vld), 5'b11111);
    bus.hazard = 1'b1;
    #1;
    check("t2_en_masked", int'(bus.stage_en[1:0]), 0);
    step();
    step();
    check("t2_vld_bubbles", int'(bus.stage_vld), 5'b10011);
    check("t2_fetch_frozen", int'(bus.fetch_cnt), 5);
    bus.hazard = 1'b0;
    wait_finish(cyc);
    check("t2_retire", int'(bus.retire_cnt), 8);

    // Flush on a full pipe.
    start_run();
    repeat (5) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("t3_vld", int'(bus.stage_vld), 5'b11001);
    wait_finish(cyc);
    check("t3_fetch", int'(bus.fetch_cnt), 8);
    check("t3_retire", int'(bus.retire_cnt), 6);

    // HALT decoded in ID.
    start_run();
    repeat (3) step();
    bus.halt_dec = 1'b1;
    step();
    bus.halt_dec = 1'b0;
    check("t4_vld", int'(bus.stage_vld), 5'b01100);
    check("t4_busy", int'(bus.busy), 1);
    wait_finish(cyc);
    check("t4_fetch", int'(bus.fetch_cnt), 3);
    check("t4_retire", int'(bus.retire_cnt), 2);

    // Flush beats halt, flush beats hazard.
    start_run();
    repeat (3) step();
    bus.flush    = 1'b1;
    bus.halt_dec = 1'b1;
    step();
    clear_in();
    check("t5_vld_a", int'(bus.stage_vld), 5'b01001);
    check("t5_fetch_a", int'(bus.fetch_cnt), 4);
    step();
    bus.flush  = 1'b1;
    bus.hazard = 1'b1;
    #1;
    check("t5_en_no_stall", int'(bus.stage_en), 5'b10011);
    step();
    clear_in();
    check("t5_vld_b", int'(bus.stage_vld), 5'b00001);
    check("t5_fetch_b", int'(bus.fetch_cnt), 6);
    wait_finish(cyc);

    // Start while busy is ignored; async reset mid-run.
    start_run();
    repeat (4) step();
    fc_before = int'(bus.fetch_cnt);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("t6_start_ignored", int'(bus.fetch_cnt), fc_before + 1);
    rstb = 1'b0;
    #1;
    check("t6_rst_vld", int'(bus.stage_vld), 0);
    check("t6_rst_en", int'(bus.stage_en), 0);
    check("t6_rst_busy", int'(bus.busy), 0);
    check("t6_rst_fin", int'(bus.opr_finished), 0);
    check("t6_rst_fetch", int'(bus.fetch_cnt), 0);
    check("t6_rst_retire", int'(bus.retire_cnt), 0);
    @(negedge clk);
    #1;
    rstb = 1'b1;
    step();
    check("t6_idle_after", int'(bus.busy), 0);

    // Randomized runs checked by the model every cycle.
    for (int r = 0; r < 30; r++) begin
      int n;
      start_run();
      n = 0;
      while (!bus.opr_finished && n < 400) begin
        bus.hazard   = ($urandom_range(99) < 25);
        bus.flush    = ($urandom_range(99) < 10);
        bus.halt_dec = ($urandom_range(99) < 5);
        bus.start    = ($urandom_range(99) < 10);
        step();
        n++;
      end
      clear_in();
      if (!bus.opr_finished) check("rand_timeout", 0, 1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
